// File: rtl/mult_pkg.sv
// Shared widths and FSM state encoding for the 8x8 radix-4 Booth multiplier stages.
package mult_pkg;

    localparam int PP_W   = 10;
    localparam int NUM_PP = 4;
    localparam int OUT_W  = 16;
    localparam int STEP_W = $clog2(NUM_PP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pp_shift_ext.sv
// Sign-extends one partial product to product width and weights it by 4^step.
module pp_shift_ext
    import mult_pkg::*;
(
    input  logic [PP_W-1:0]   pp,
    input  logic [STEP_W-1:0] step,
    output logic [OUT_W-1:0]  term
);

    logic [OUT_W-1:0] ext;

    // Extension must precede the shift so negative terms stay negative after weighting.
    assign ext  = {{(OUT_W-PP_W){pp[PP_W-1]}}, pp};
    assign term = ext << {step, 1'b0};

endmodule

// File: rtl/pp_accumulator.sv
// Iterative accumulator summing four Booth partial products (weight 4^i) into a 16-bit product.
module pp_accumulator
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  pp0,
    input  logic [PP_W-1:0]  pp1,
    input  logic [PP_W-1:0]  pp2,
    input  logic [PP_W-1:0]  pp3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] product,
    output logic             busy
);

    state_t state_reg, state_next;

    logic [STEP_W-1:0] step_reg;
    logic [OUT_W-1:0]  acc_reg;
    logic [OUT_W-1:0]  product_reg;
    logic [OUT_W-1:0]  term;
    logic [OUT_W-1:0]  sum;
    logic [PP_W-1:0]   pp_in  [NUM_PP];
    logic [PP_W-1:0]   pp_reg [NUM_PP];
    logic              accept;
    logic              last_step;

    assign pp_in[0] = pp0;
    assign pp_in[1] = pp1;
    assign pp_in[2] = pp2;
    assign pp_in[3] = pp3;

    assign accept    = in_valid && (state_reg == IDLE);
    assign last_step = (step_reg == STEP_W'(NUM_PP-1));

    pp_shift_ext u_shift_ext (
        .pp   (pp_reg[step_reg]),
        .step (step_reg),
        .term (term)
    );

    assign sum = acc_reg + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept)    state_next = ACC;
            ACC:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Partial products are captured only on acceptance, so input changes mid-flight are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PP; i++) begin
                pp_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NUM_PP; i++) begin
                pp_reg[i] <= pp_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_reg    <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        step_reg <= '0;
                        acc_reg  <= '0;
                    end
                end
                ACC: begin
                    acc_reg  <= sum;
                    step_reg <= step_reg + STEP_W'(1);
                    if (last_step) begin
                        product_reg <= sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign product   = product_reg;

endmodule

// File: tb/tb_pp_accumulator.sv
// Scoreboard bench for pp_accumulator: directed corners, back-to-back traffic, backpressure and mid-op reset.
module tb_pp_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  pp0, pp1, pp2, pp3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks;
    int n_fail;
    logic [15:0] exp_q [$];

    pp_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish before limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [9:0] a, b, c, d);
        int s;
        s = $signed(a) + $signed(b) * 4 + $signed(c) * 16 + $signed(d) * 64;
        return s[15:0];
    endfunction

    // Drive one set at a negedge; returns at the negedge right after the accepting edge.
    task automatic accept_set(input logic [9:0] a, b, c, d);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        pp0 = a; pp1 = b; pp2 = c; pp3 = d;
        in_valid = 1'b1;
        exp_q.push_back(model(a, b, c, d));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        pp0 = 10'($urandom); pp1 = 10'($urandom);
        pp2 = 10'($urandom); pp3 = 10'($urandom);
    endtask

    // Wait for out_valid, check latency and product against scoreboard head.
    task automatic wait_result(input string name);
        int cnt;
        logic [15:0] exp;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_busy: busy=%b in_ready=%b required busy=1 in_ready=0", name, busy, in_ready);
            end
            @(negedge clk);
            cnt++;
        end
        n_checks++;
        if (cnt != 4) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles required 4", name, cnt);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        n_checks++;
        if (product !== exp) begin
            n_fail++;
            $display("FAIL %s_product: product=%h required %h", name, product, exp);
        end
        $display("txn %s: product=%h expected=%h latency=%0d", name, product, exp, cnt);
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", name, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b product=%h busy=%b required 1/0/0000/0",
                     in_ready, out_valid, product, busy);
        end
        $display("txn reset: in_ready=%b out_valid=%b product=%h", in_ready, out_valid, product);
    endtask

    task automatic test_directed;
        accept_set(10'd1, 10'd0, 10'd0, 10'd0);
        wait_result("basic");
        consume("basic");
        accept_set(10'h3FE, 10'd1, 10'd0, 10'd0);
        wait_result("signed");
        consume("signed");
        accept_set(10'd0, 10'd0, 10'd0, 10'd256);
        wait_result("booth");
        consume("booth");
        accept_set(10'h200, 10'h200, 10'h200, 10'h200);
        wait_result("wrap");
        consume("wrap");
    endtask

    // out_ready held high: DONE lasts one cycle, next accept two edges after out_valid.
    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            accept_set(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
            wait_result($sformatf("b2b%0d", i));
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_return: out_valid=%b in_ready=%b required 0/1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure_reset;
        logic [15:0] held;
        accept_set(10'h155, 10'h0AA, 10'h3C3, 10'h07F);
        wait_result("bp");
        held = model(10'h155, 10'h0AA, 10'h3C3, 10'h07F);
        for (int i = 0; i < 3; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            pp0 = 10'($urandom); pp3 = 10'($urandom);
            @(negedge clk);
            n_checks++;
            if (product !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: product=%h out_valid=%b in_ready=%b required %h/1/0",
                         i, product, out_valid, in_ready, held);
            end
        end
        in_valid = 1'b0;
        consume("bp");
        accept_set(10'd7, 10'd7, 10'd7, 10'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'h0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_reset: out_valid=%b in_ready=%b product=%h busy=%b required 0/1/0000/0",
                     out_valid, in_ready, product, busy);
        end
        void'(exp_q.pop_back());
        $display("txn midop_reset: out_valid=%b product=%h", out_valid, product);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset%0d: out_valid=%b busy=%b required 0/0", i, out_valid, busy);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pp0 = '0; pp1 = '0; pp2 = '0; pp3 = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pp_accumulator.md
# pp_accumulator

Sequential partial-product accumulator that sits directly downstream of the radix-4 Booth partial-product generator in the 8x8 multiplier. It captures the four 10-bit signed partial products in one handshake and sums them over four clock cycles, each weighted by 4^i. It then presents the 16-bit product under a valid/ready handshake. It replaces a flat adder tree with a small area-lean iterative datapath.

## Interface
- PP_W, 10, partial-product width (signed, two's complement)
- NUM_PP, 4, number of partial products; shift per step is 2 bits
- OUT_W, 16, product width
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  pp0..pp3 are valid
- in_ready  output  1  accumulator can accept a new set
- pp0, pp1, pp2, pp3  input  PP_W each  signed partial products, pp_i has weight 4^i
- out_valid  output  1  product is valid
- out_ready  input  1  consumer accepts product
- product  output  OUT_W  signed product, sum of pp_i·4^i modulo 2^OUT_W
- busy  output  1  high in ACC and DONE states

## Operation
- FSM states are IDLE, ACC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register pp0..pp3 into the pp_reg array, clear acc, set step=0 and go to ACC.
- ACC:
  - Each cycle, acc <= acc + (sext(pp_reg[step]) << 2·step), truncated to OUT_W. Sign extension to OUT_W happens before the shift.
  - step increments 0→3. On step==3, the final sum loads into product, out_valid<=1, and the FSM goes to DONE.
- DONE:
  - out_valid=1 and product is held stable.
  - On out_ready, go to IDLE and drop out_valid. There is no same-cycle acceptance of new input in this transition.
- in_ready is 0 in ACC and DONE. in_valid is ignored in those states; input changes there do not affect the in-flight result.
- Overflow wraps modulo 2^16 silently. There is no saturation or flag.
- out_ready while in IDLE or ACC is ignored.

## Timing
- Reset values: in_ready=1, out_valid=0, product=16'h0000, busy=0. Internally, state=IDLE, step=0, acc=0 and pp_reg=0.
- Accept at edge k. ACC updates happen at edges k+1..k+4, and out_valid is visible after edge k+4. Latency is 4 cycles from acceptance.
- If out_ready is already high in DONE, the FSM returns to IDLE at edge k+5 and can accept at edge k+6. Maximum throughput is one product per 6 cycles.
- Backpressure: DONE holds product and out_valid indefinitely while out_ready=0.
- Reset asserted mid-operation (ACC or DONE):
  - The state returns to IDLE asynchronously and all outputs return to their reset values.
  - The in-flight result is discarded; no partial product is emitted.

## Structure
- The shared package mult_pkg holds:
  - PP_W, OUT_W and NUM_PP
  - the state enum (IDLE, ACC, DONE)
  - the step width, which is $clog2(NUM_PP)
- The generator and other multiplier stages take widths from mult_pkg.
- One sub-module, pp_shift_ext, is combinational. It sign-extends a PP_W value to OUT_W and left-shifts it by 2·step.
- The top level holds the FSM, pp_reg, acc, step and the adder.

## Test plan
- Reset check: hold rst_n=0, then release → in_ready=1, out_valid=0, product=0000.
- Basic case: pp0=1 with pp1..pp3=0, accept at edge k → out_valid rises after edge k+4 and product=16'h0001.
- Signed weighting: pp0=10'h3FE (−2), pp1=1, pp2=pp3=0 → product=16'h0002.
- Booth corner:
  - Stimulus: pp0=pp1=pp2=0, pp3=256 (X=−128, Y=−128 from the generator).
  - Required response: product=16'h4000.
- Wrap-around:
  - Stimulus: all pp=10'h200 (−512).
  - Required response: product=16'h5600, which is −43520 mod 2^16.
- Backpressure plus reset mid-op:
  - Hold out_ready=0 for 3 cycles in DONE → product is stable, in_ready=0, and in_valid pulses are ignored.
  - Then accept a new set and assert rst_n=0 at the second ACC cycle → immediately IDLE with out_valid=0 and product=0000, and no output after release.
